// File: rtl/conv_pkg.sv
// Shared constants for the K=3 rate-1/2 convolutional link: generators, trellis width,
// FSM encoding and the rate-2/3 puncture pattern, used by both encoder and decoder.
package conv_pkg;

  localparam int K      = 3;
  localparam int S_W    = K - 1;
  localparam int TAIL_W = (K > 2) ? $clog2(K - 1) : 1;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // Puncture pattern [11;10]: upper pair for even data bits, lower pair for odd.
  localparam logic [3:0] PUNCT_PAT = 4'b11_10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } conv_state_e;

endpackage

// File: rtl/conv_frame_encoder_if.sv
// Input word stream and output symbol stream of the convolutional encoder.
// Both streams use valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface conv_frame_encoder_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [1:0]        sym;
  logic [1:0]        sym_mask;
  logic              sym_valid;
  logic              sym_last;
  logic              sym_ready;

  modport master (
    output in_data, in_valid, in_last, sym_ready,
    input  in_ready, sym, sym_mask, sym_valid, sym_last
  );

  modport slave (
    input  in_data, in_valid, in_last, sym_ready,
    output in_ready, sym, sym_mask, sym_valid, sym_last
  );

endinterface

// File: rtl/conv_core.sv
// Combinational trellis step: (u, s) -> (sym, next_s). Shared with the decoder's
// branch-label generation so both ends agree on the generators.
module conv_core
  import conv_pkg::*;
(
  input  logic           u,
  input  logic [S_W-1:0] s,
  output logic [1:0]     sym,
  output logic [S_W-1:0] next_s
);

  logic [K-1:0] taps;

  assign taps   = {u, s};
  assign sym    = {^(taps & G0), ^(taps & G1)};
  assign next_s = {u, s[S_W-1:1]};

endmodule

// File: rtl/conv_frame_encoder.sv
// Framed K=3 rate-1/2 convolutional encoder: bytes in MSB-first, one symbol per bit,
// then K-1 zero tail symbols. Define PUNCTURE_EN for rate-2/3 puncturing of data bits.
module conv_frame_encoder
  import conv_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_frame_encoder_if.slave  bus,
  output conv_state_e          dbg_state
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(K - 2);

  conv_state_e       state;
  logic [DATA_W-1:0] shreg;
  logic              last_flag;
  logic              pad;
  logic [S_W-1:0]    s;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TAIL_W-1:0] tail_cnt;

  logic           u;
  logic           valid_int;
  logic           fire;
  logic           accept;
  logic           final_bit;
  logic           ready;
  logic           tail_last;
  logic [1:0]     core_sym;
  logic [1:0]     mask;
  logic [S_W-1:0] next_s;

  conv_core u_core (
    .u      (u),
    .s      (s),
    .sym    (core_sym),
    .next_s (next_s)
  );

  assign u         = (state == DATA) ? shreg[DATA_W-1] : 1'b0;
  assign final_bit = (bit_cnt == LAST_BIT);
  assign valid_int = ((state == DATA) && !pad) || (state == TAIL);
  assign tail_last = (state == TAIL) && (tail_cnt == LAST_TAIL);
  assign fire      = valid_int && bus.sym_ready;

  // The final-bit term depends on sym_ready so the next word loads on the same edge
  // the last bit leaves, giving gap-free back-to-back words.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      DATA:    ready = pad || (final_bit && !last_flag && bus.sym_ready);
      default: ready = 1'b0;
    endcase
  end

  assign bus.in_ready = rst && ready;
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef PUNCTURE_EN
  logic parity;
  assign mask = ((state == DATA) && parity) ? PUNCT_PAT[1:0] : PUNCT_PAT[3:2];
`else
  assign mask = 2'b11;
`endif

  assign bus.sym_valid = valid_int;
  assign bus.sym_mask  = valid_int ? mask : 2'b00;
  assign bus.sym       = valid_int ? (core_sym & mask) : 2'b00;
  assign bus.sym_last  = tail_last;
  assign dbg_state     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      last_flag <= 1'b0;
      pad       <= 1'b0;
      s         <= '0;
      bit_cnt   <= '0;
      tail_cnt  <= '0;
`ifdef PUNCTURE_EN
      parity    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg     <= bus.in_data;
            last_flag <= bus.in_last;
            bit_cnt   <= '0;
            pad       <= 1'b0;
            s         <= '0;
            state     <= DATA;
`ifdef PUNCTURE_EN
            parity    <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (pad) begin
            if (accept) begin
              shreg     <= bus.in_data;
              last_flag <= bus.in_last;
              pad       <= 1'b0;
            end
          end else if (fire) begin
            s <= next_s;
`ifdef PUNCTURE_EN
            parity <= ~parity;
`endif
            if (final_bit) begin
              bit_cnt <= '0;
              if (last_flag) begin
                tail_cnt <= '0;
                state    <= TAIL;
              end else if (accept) begin
                shreg     <= bus.in_data;
                last_flag <= bus.in_last;
              end else begin
                pad <= 1'b1;
              end
            end else begin
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        TAIL: begin
          if (fire) begin
            s <= next_s;
            if (tail_last) begin
              state <= IDLE;
            end else begin
              tail_cnt <= tail_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Bench for conv_frame_encoder: directed vectors, stalls, mid-frame reset and random
// frames checked against a bit-history reference model and a round-trip inversion.
module tb_conv_frame_encoder;
  import conv_pkg::*;

  localparam int DATA_W = 8;
`ifdef PUNCTURE_EN
  localparam bit PUNCT = 1'b1;
`else
  localparam bit PUNCT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  conv_state_e dbg_state;

  conv_frame_encoder_if #(.DATA_W(DATA_W)) bus ();

  conv_frame_encoder #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;

  logic [4:0]        got_q[$];
  logic [4:0]        exp_q[$];
  logic [1:0]        dir_q[$];
  logic [DATA_W-1:0] word_q[$];
  logic              bits_q[$];
  int                fire_cyc_q[$];
  int                acc_cyc_q[$];
  logic              hold_v = 1'b0;
  logic [4:0]        hold = '0;

  // sym_ready driver: 0 = always ready, 1 = toggle, 2 = random stalls
  initial begin
    bus.sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.sym_ready = ~bus.sym_ready;
        2:       bus.sym_ready = ($urandom_range(0, 3) != 0);
        default: bus.sym_ready = 1'b1;
      endcase
    end
  end

  // Symbol monitor: records fires, checks symbols hold still while stalled
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst && hold_v && !bus.sym_valid) begin
        checks++;
        errors++;
        $display("FAIL stall_valid sym_valid=0 required=1");
        hold_v = 1'b0;
      end
      if (rst && bus.sym_valid) begin
        if (hold_v) begin
          checks++;
          if ({bus.sym_last, bus.sym_mask, bus.sym} !== hold) begin
            errors++;
            $display("FAIL stall_stable got=%b required=%b",
                     {bus.sym_last, bus.sym_mask, bus.sym}, hold);
          end
        end
        if (bus.sym_ready) begin
          got_q.push_back({bus.sym_last, bus.sym_mask, bus.sym});
          fire_cyc_q.push_back(cyc);
          hold_v = 1'b0;
        end else begin
          hold_v = 1'b1;
          hold   = {bus.sym_last, bus.sym_mask, bus.sym};
        end
      end else begin
        hold_v = 1'b0;
      end
      if (rst && bus.in_valid && bus.in_ready) acc_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_queues();
    got_q.delete();
    exp_q.delete();
    fire_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
    int n = 0;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_word_timeout in_ready=%0b required=1", bus.in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_syms(input int n);
    int c = 0;
    while (got_q.size() < n && c < 3000) begin
      @(posedge clk);
      #2;
      c++;
    end
    checks++;
    if (got_q.size() < n) begin
      errors++;
      $display("FAIL wait_syms got=%0d required=%0d", got_q.size(), n);
    end
  endtask

  // Directed expectation: table symbols, masked on odd data bits when punctured
  function automatic void build_dir(input int nd);
    logic [1:0] m;
    exp_q.delete();
    for (int i = 0; i < dir_q.size(); i++) begin
      m = (PUNCT && i < nd && (i % 2) == 1) ? 2'b10 : 2'b11;
      exp_q.push_back({(i == dir_q.size() - 1), m, dir_q[i] & m});
    end
  endfunction

  // Reference model from the bit history: y1 = b[i]^b[i-1]^b[i-2], y0 = b[i]^b[i-2]
  function automatic void build_model();
    int         nd;
    logic       b0, b1, b2;
    logic [1:0] m;
    bits_q.delete();
    exp_q.delete();
    foreach (word_q[w])
      for (int j = DATA_W - 1; j >= 0; j--) bits_q.push_back(word_q[w][j]);
    nd = bits_q.size();
    for (int t = 0; t < K - 1; t++) bits_q.push_back(1'b0);
    for (int i = 0; i < bits_q.size(); i++) begin
      b0 = bits_q[i];
      b1 = (i >= 1) ? bits_q[i-1] : 1'b0;
      b2 = (i >= 2) ? bits_q[i-2] : 1'b0;
      m  = (PUNCT && i < nd && (i % 2) == 1) ? 2'b10 : 2'b11;
      exp_q.push_back({(i == bits_q.size() - 1), m, {b0 ^ b1 ^ b2, b0 ^ b2} & m});
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL reset_sym_valid got=%b required=0", bus.sym_valid); end
    checks++; if (bus.sym !== 2'b00) begin errors++; $display("FAIL reset_sym got=%b required=00", bus.sym); end
    checks++; if (bus.sym_mask !== 2'b00) begin errors++; $display("FAIL reset_sym_mask got=%b required=00", bus.sym_mask); end
    checks++; if (bus.sym_last !== 1'b0) begin errors++; $display("FAIL reset_sym_last got=%b required=0", bus.sym_last); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b required=0", bus.in_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d required=%0d", dbg_state, IDLE); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b required=1", bus.in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word(input string name);
    clear_queues();
    dir_q = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    build_dir(8);
    send_word(8'hB0, 1'b1);
    bus.in_valid = 1'b0;
    wait_syms(10);
    repeat (3) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s_count got=%0d required=%0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_sym%0d got=%b required=%b", name, i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_end_in_ready got=%b required=1", name, bus.in_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL %s_end_state got=%0d required=%0d", name, dbg_state, IDLE); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    clear_queues();
    dir_q = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
              2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
              2'b00, 2'b00};
    build_dir(16);
    send_word(8'hFF, 1'b0);
    send_word(8'h00, 1'b1);
    bus.in_valid = 1'b0;
    wait_syms(18);
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_sym%0d got=%b required=%b", i, got_q[i], exp_q[i]);
      end
    end
    if (fire_cyc_q.size() == 18) begin
      checks++;
      if (fire_cyc_q[17] - fire_cyc_q[0] !== 17) begin
        errors++; $display("FAIL b2b_no_gap span=%0d required=17", fire_cyc_q[17] - fire_cyc_q[0]);
      end
    end
    checks++;
    if (acc_cyc_q.size() !== 2) begin
      errors++; $display("FAIL b2b_accepts got=%0d required=2", acc_cyc_q.size());
    end else if (fire_cyc_q.size() >= 8) begin
      checks++;
      if (acc_cyc_q[1] !== fire_cyc_q[7]) begin
        errors++; $display("FAIL b2b_accept_cycle got=%0d required=%0d", acc_cyc_q[1], fire_cyc_q[7]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    ready_mode = 1;
    test_single_word("stall");
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    clear_queues();
    send_word(8'hB0, 1'b1);
    bus.in_valid = 1'b0;
    wait_syms(3);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.sym_valid !== 1'b0) begin errors++; $display("FAIL midrst_sym_valid got=%b required=0", bus.sym_valid); end
    checks++; if (bus.sym !== 2'b00) begin errors++; $display("FAIL midrst_sym got=%b required=00", bus.sym); end
    checks++; if (bus.sym_mask !== 2'b00) begin errors++; $display("FAIL midrst_sym_mask got=%b required=00", bus.sym_mask); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b required=0", bus.in_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL midrst_state got=%0d required=%0d", dbg_state, IDLE); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_single_word("after_rst");
  endtask

  task automatic test_random_frames();
    int nw;
    logic p1, p2, u;
    ready_mode = 2;
    for (int f = 0; f < 6; f++) begin
      clear_queues();
      word_q.delete();
      nw = $urandom_range(1, 16);
      for (int w = 0; w < nw; w++) word_q.push_back(DATA_W'($urandom));
      build_model();
      for (int w = 0; w < nw; w++) begin
        if (w > 0 && $urandom_range(0, 2) == 0) begin
          bus.in_valid = 1'b0;
          repeat ($urandom_range(1, 12)) @(posedge clk);
          #1;
        end
        send_word(word_q[w], (w == nw - 1));
      end
      bus.in_valid = 1'b0;
      wait_syms(exp_q.size());
      repeat (2) @(negedge clk);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count got=%0d required=%0d", f, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_sym%0d got=%b required=%b", f, i, got_q[i], exp_q[i]);
        end
      end
      // Round trip: invert the code from the received symbols alone
      p1 = 1'b0;
      p2 = 1'b0;
      for (int i = 0; i < got_q.size() && i < bits_q.size(); i++) begin
        u = got_q[i][2] ? (got_q[i][0] ^ p2) : (got_q[i][1] ^ p1 ^ p2);
        checks++;
        if (u !== bits_q[i]) begin
          errors++; $display("FAIL rand%0d_decode%0d got=%b required=%b", f, i, u, bits_q[i]);
        end
        p2 = p1;
        p1 = u;
      end
      checks++;
      if ({p1, p2} !== 2'b00) begin
        errors++; $display("FAIL rand%0d_end_trellis got=%b required=00", f, {p1, p2});
      end
      checks++;
      if (dbg_state !== IDLE) begin
        errors++; $display("FAIL rand%0d_end_state got=%0d required=%0d", f, dbg_state, IDLE);
      end
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
  endtask

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst          = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single_word("single");
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
